// File: rtl/bullet_slot_arbiter_if.sv
// Request/slot bundle between the tank logic and the bullet slot arbiter.
// The master drives fire requests and hits; the slave reports acks and slot state.
interface bullet_slot_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_SLOTS = 4
);
    localparam int unsigned OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           fire_req;
    logic [NUM_REQ*10-1:0]        req_x;
    logic [NUM_REQ*10-1:0]        req_y;
    logic [NUM_REQ*4-1:0]         req_dir;
    logic [NUM_SLOTS-1:0]         hit;
    logic [NUM_REQ-1:0]           fire_ack;
    logic [NUM_SLOTS-1:0]         slot_active;
    logic [NUM_SLOTS*10-1:0]      slot_x;
    logic [NUM_SLOTS*10-1:0]      slot_y;
    logic [NUM_SLOTS*4-1:0]       slot_dir;
    logic [NUM_SLOTS*OWNER_W-1:0] slot_owner;

    modport master (
        output fire_req, req_x, req_y, req_dir, hit,
        input  fire_ack, slot_active, slot_x, slot_y, slot_dir, slot_owner
    );

    modport slave (
        input  fire_req, req_x, req_y, req_dir, hit,
        output fire_ack, slot_active, slot_x, slot_y, slot_dir, slot_owner
    );
endinterface

// File: rtl/bullet_slot_arbiter.sv
// Shares a pool of bullet slots among tanks: one round-robin grant per frame,
// moves live bullets and retires them on a hit or at the playfield edge.
module bullet_slot_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned BULLET_STEP = 2,
    parameter int unsigned X_MIN       = 80,
    parameter int unsigned X_MAX       = 559,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned COOLDOWN    = 16,
    parameter int unsigned MAX_PER_REQ = 1
) (
    input logic                  frame_clk,
    input logic                  Reset,
    bullet_slot_arbiter_if.slave bus
);
    localparam int unsigned OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned OWN_W   = $clog2(MAX_PER_REQ + 1);

    localparam logic [10:0] STEP   = 11'(BULLET_STEP);
    localparam logic [9:0]  STEP10 = 10'(BULLET_STEP);
    localparam logic [10:0] XLO    = 11'(X_MIN);
    localparam logic [10:0] XHI1   = 11'(X_MAX + 1);
    localparam logic [10:0] YLO    = 11'(Y_MIN);
    localparam logic [10:0] YHI1   = 11'(Y_MAX + 1);

    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [9:0]           x_q     [NUM_SLOTS];
    logic [9:0]           x_d     [NUM_SLOTS];
    logic [9:0]           y_q     [NUM_SLOTS];
    logic [9:0]           y_d     [NUM_SLOTS];
    logic [3:0]           dir_q   [NUM_SLOTS];
    logic [3:0]           dir_d   [NUM_SLOTS];
    logic [OWNER_W-1:0]   owner_q [NUM_SLOTS];
    logic [OWNER_W-1:0]   owner_d [NUM_SLOTS];
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [OWNER_W-1:0]   rr_q, rr_d;
    logic [CD_W-1:0]      cd_q    [NUM_REQ];
    logic [CD_W-1:0]      cd_d    [NUM_REQ];
    logic [OWN_W-1:0]     owned_q [NUM_REQ];
    logic [OWN_W-1:0]     owned_d [NUM_REQ];

    logic [10:0]          rx        [NUM_REQ];
    logic [10:0]          ry        [NUM_REQ];
    logic [3:0]           rd        [NUM_REQ];
    logic [9:0]           spawn_x   [NUM_REQ];
    logic [9:0]           spawn_y   [NUM_REQ];
    logic [NUM_REQ-1:0]   in_bounds;
    logic [NUM_REQ-1:0]   elig;
    logic                 leaving;
    logic                 grant;
    logic                 any_free;
    logic [OWNER_W-1:0]   win;
    logic [OWNER_W-1:0]   idx;
    logic [SLOT_W-1:0]    free_slot;

    // Non-one-hot directions fall to the default arm and are never in bounds.
    always_comb begin
        in_bounds = '0;
        elig      = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rx[r]      = {1'b0, bus.req_x[10*r +: 10]};
            ry[r]      = {1'b0, bus.req_y[10*r +: 10]};
            rd[r]      = bus.req_dir[4*r +: 4];
            spawn_x[r] = rx[r][9:0];
            spawn_y[r] = ry[r][9:0];
            case (rd[r])
                4'b0001: begin
                    in_bounds[r] = ry[r] >= YLO + 11'd8;
                    spawn_x[r]   = 10'(rx[r] + 11'd12);
                    spawn_y[r]   = 10'(ry[r] - 11'd8);
                end
                4'b0010: begin
                    in_bounds[r] = ry[r] + 11'd40 <= YHI1;
                    spawn_x[r]   = 10'(rx[r] + 11'd12);
                    spawn_y[r]   = 10'(ry[r] + 11'd32);
                end
                4'b0100: begin
                    in_bounds[r] = rx[r] >= XLO + 11'd8;
                    spawn_x[r]   = 10'(rx[r] - 11'd8);
                    spawn_y[r]   = 10'(ry[r] + 11'd12);
                end
                4'b1000: begin
                    in_bounds[r] = rx[r] + 11'd40 <= XHI1;
                    spawn_x[r]   = 10'(rx[r] + 11'd32);
                    spawn_y[r]   = 10'(ry[r] + 11'd12);
                end
                default: in_bounds[r] = 1'b0;
            endcase
            elig[r] = bus.fire_req[r] && (cd_q[r] == '0) &&
                      (owned_q[r] < OWN_W'(MAX_PER_REQ)) && in_bounds[r];
        end
    end

    always_comb begin
        active_d  = active_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        owner_d   = owner_q;
        owned_d   = owned_q;
        ack_d     = '0;
        rr_d      = rr_q;
        leaving   = 1'b0;
        grant     = 1'b0;
        any_free  = 1'b0;
        win       = '0;
        idx       = '0;
        free_slot = '0;

        for (int r = 0; r < NUM_REQ; r++) begin
            cd_d[r] = (cd_q[r] != '0) ? cd_q[r] - 1'b1 : '0;
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_q[i]) begin
                case (dir_q[i])
                    4'b0001: leaving = {1'b0, y_q[i]} < YLO + STEP;
                    4'b0010: leaving = {1'b0, y_q[i]} + 11'd8 + STEP > YHI1;
                    4'b0100: leaving = {1'b0, x_q[i]} < XLO + STEP;
                    4'b1000: leaving = {1'b0, x_q[i]} + 11'd8 + STEP > XHI1;
                    default: leaving = 1'b1;
                endcase
                if (bus.hit[i] || leaving) begin
                    active_d[i]         = 1'b0;
                    owned_d[owner_q[i]] = owned_d[owner_q[i]] - 1'b1;
                end else begin
                    case (dir_q[i])
                        4'b0001: y_d[i] = y_q[i] - STEP10;
                        4'b0010: y_d[i] = y_q[i] + STEP10;
                        4'b0100: x_d[i] = x_q[i] - STEP10;
                        default: x_d[i] = x_q[i] + STEP10;
                    endcase
                end
            end
        end

        // Only slots idle at the start of the frame are grantable.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                any_free  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end

        // Descending scan so the requester closest to rr_q is the last writer.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = OWNER_W'((int'(rr_q) + k) % int'(NUM_REQ));
            if (elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end

        if (grant && any_free) begin
            active_d[free_slot] = 1'b1;
            x_d[free_slot]      = spawn_x[win];
            y_d[free_slot]      = spawn_y[win];
            dir_d[free_slot]    = rd[win];
            owner_d[free_slot]  = win;
            ack_d[win]          = 1'b1;
            cd_d[win]           = CD_W'(COOLDOWN);
            owned_d[win]        = owned_d[win] + 1'b1;
            rr_d = (int'(win) == int'(NUM_REQ) - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            active_q <= '0;
            ack_q    <= '0;
            rr_q     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                dir_q[i]   <= 4'b0001;
                owner_q[i] <= '0;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                cd_q[r]    <= '0;
                owned_q[r] <= '0;
            end
        end else begin
            active_q <= active_d;
            ack_q    <= ack_d;
            rr_q     <= rr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            owner_q  <= owner_d;
            cd_q     <= cd_d;
            owned_q  <= owned_d;
        end
    end

    assign bus.fire_ack    = ack_q;
    assign bus.slot_active = active_q;

    always_comb begin
        bus.slot_x     = '0;
        bus.slot_y     = '0;
        bus.slot_dir   = '0;
        bus.slot_owner = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.slot_x[10*i +: 10]               = x_q[i];
            bus.slot_y[10*i +: 10]               = y_q[i];
            bus.slot_dir[4*i +: 4]               = dir_q[i];
            bus.slot_owner[OWNER_W*i +: OWNER_W] = owner_q[i];
        end
    end
endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Directed bench for bullet_slot_arbiter: stimulus pushes expected grants into a
// scoreboard, a negedge monitor pops and checks them when fire_ack pulses.
module tb_bullet_slot_arbiter;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned OWNER_W   = 2;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    bullet_slot_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS)) bus ();

    bullet_slot_arbiter #(.NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int edge_no;
        int req;
        int slot;
        int x;
        int y;
        int dir;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edge_cnt   = 0;

    always @(posedge frame_clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int sx(input int s);
        return int'(bus.slot_x[10*s +: 10]);
    endfunction

    function automatic int sy(input int s);
        return int'(bus.slot_y[10*s +: 10]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic set_req(input int r, input int x, input int y, input logic [3:0] d);
        bus.req_x[10*r +: 10] = 10'(x);
        bus.req_y[10*r +: 10] = 10'(y);
        bus.req_dir[4*r +: 4] = d;
    endtask

    task automatic push(input int e, input int r, input int s, input int x, input int y,
                        input int d);
        sb.push_back('{e, r, s, x, y, d});
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        bus.fire_req = '0;
        bus.hit      = '0;
        tick(1);
        Reset = 1'b0;
    endtask

    // Monitor: every ack must match the head of the scoreboard at the expected edge.
    always @(negedge frame_clk) begin
        exp_t e;
        if (bus.fire_ack != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(bus.fire_ack), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_edge", 64'(edge_cnt), 64'(e.edge_no));
                chk("ack_vec", 64'(bus.fire_ack), 64'(1 << e.req));
                chk("grant_active", 64'(bus.slot_active[e.slot]), 64'd1);
                chk("grant_x", 64'(sx(e.slot)), 64'(e.x));
                chk("grant_y", 64'(sy(e.slot)), 64'(e.y));
                chk("grant_dir", 64'(bus.slot_dir[4*e.slot +: 4]), 64'(e.dir));
                chk("grant_owner", 64'(bus.slot_owner[OWNER_W*e.slot +: OWNER_W]), 64'(e.req));
            end
        end else if (sb.size() != 0 && sb[0].edge_no <= edge_cnt) begin
            chk("missing_ack", 64'd0, 64'(1 << sb[0].req));
            void'(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.fire_req = '0;
        bus.hit      = '0;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 0, 0, 4'b0001);
        Reset = 1'b1;
        tick(2);
        chk("rst_active", 64'(bus.slot_active), 64'd0);
        chk("rst_x", 64'(bus.slot_x), 64'd0);
        chk("rst_y", 64'(bus.slot_y), 64'd0);
        chk("rst_dir", 64'(bus.slot_dir), 64'h1111);
        chk("rst_owner", 64'(bus.slot_owner), 64'd0);
        chk("rst_ack", 64'(bus.fire_ack), 64'd0);

        // Single shot upward from (320,240); held request re-fires after the exit.
        set_req(0, 320, 240, 4'b0001);
        bus.fire_req = 4'b0001;
        Reset        = 1'b0;
        base         = edge_cnt;
        push(base + 1, 0, 0, 332, 232, 1);
        tick(2);
        chk("ss_y_edge2", 64'(sy(0)), 64'd230);
        chk("ss_ack_edge2", 64'(bus.fire_ack), 64'd0);
        tick(115);
        chk("ss_active_y0", 64'(bus.slot_active[0]), 64'd1);
        chk("ss_y0", 64'(sy(0)), 64'd0);
        tick(1);
        chk("ss_freed", 64'(bus.slot_active[0]), 64'd0);
        push(base + 119, 0, 0, 332, 232, 1);
        tick(1);
        bus.fire_req = '0;
        tick(1);

        // Round-robin fill, pool full, then hit on slot1 and cooldown-gated re-grant.
        do_reset();
        set_req(0, 200, 200, 4'b0001);
        set_req(1, 300, 200, 4'b0010);
        set_req(2, 400, 200, 4'b0100);
        set_req(3, 150, 300, 4'b1000);
        bus.fire_req = 4'hf;
        base         = edge_cnt;
        push(base + 1, 0, 0, 212, 192, 1);
        push(base + 2, 1, 1, 312, 232, 2);
        push(base + 3, 2, 2, 392, 212, 4);
        push(base + 4, 3, 3, 182, 312, 8);
        tick(5);
        chk("rr_pool_full", 64'(bus.slot_active), 64'hf);
        chk("rr_no_ack", 64'(bus.fire_ack), 64'd0);
        chk("rr_slot0_moved", 64'(sy(0)), 64'd184);
        bus.hit = 4'b0010;
        tick(1);
        bus.hit = '0;
        chk("rr_hit_frees", 64'(bus.slot_active), 64'b1101);
        push(base + 19, 1, 1, 312, 232, 2);
        tick(14);

        // Hit at x=550 moving right; the same-edge request must land in slot1.
        do_reset();
        set_req(3, 518, 100, 4'b1000);
        bus.fire_req = 4'b1000;
        base         = edge_cnt;
        push(base + 1, 3, 0, 550, 112, 8);
        tick(1);
        set_req(0, 200, 200, 4'b0001);
        bus.fire_req = 4'b1001;
        bus.hit      = 4'b0001;
        push(base + 2, 0, 1, 212, 192, 1);
        tick(1);
        bus.hit      = '0;
        bus.fire_req = 4'b1000;
        chk("hx_active", 64'(bus.slot_active), 64'b0010);
        push(base + 18, 3, 0, 550, 112, 8);
        tick(17);

        // Out-of-bounds left spawn and non-one-hot direction are both ignored.
        do_reset();
        set_req(2, 85, 200, 4'b0100);
        set_req(1, 300, 200, 4'b0011);
        bus.fire_req = 4'b0110;
        tick(4);
        chk("sb_no_ack", 64'(bus.fire_ack), 64'd0);
        chk("sb_no_active", 64'(bus.slot_active), 64'd0);
        set_req(0, 200, 200, 4'b0001);
        set_req(3, 150, 300, 4'b1000);
        bus.fire_req = 4'hf;
        base         = edge_cnt;
        push(base + 1, 0, 0, 212, 192, 1);
        push(base + 2, 3, 1, 182, 312, 8);
        tick(2);
        set_req(1, 300, 200, 4'b0010);
        bus.fire_req = 4'b0011;
        push(base + 3, 1, 2, 312, 232, 2);
        tick(1);
        chk("mf_three_active", 64'(bus.slot_active), 64'b0111);

        // Reset mid-flight with req0 held; it must be granted right after release.
        Reset        = 1'b1;
        bus.fire_req = 4'b0001;
        tick(1);
        Reset = 1'b0;
        chk("mf_active", 64'(bus.slot_active), 64'd0);
        chk("mf_x", 64'(bus.slot_x), 64'd0);
        chk("mf_y", 64'(bus.slot_y), 64'd0);
        chk("mf_dir", 64'(bus.slot_dir), 64'h1111);
        chk("mf_owner", 64'(bus.slot_owner), 64'd0);
        chk("mf_ack", 64'(bus.fire_ack), 64'd0);
        push(edge_cnt + 1, 0, 0, 212, 192, 1);
        tick(2);
        bus.fire_req = '0;
        tick(1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bullet_slot_arbiter.md
Name: bullet_slot_arbiter

Overview:
- Shares a fixed pool of bullet slots between the player tank and the enemy tanks.
- Each frame it grants at most one fire request, round-robin, subject to per-requester cooldown and ownership limits, and spawns the bullet at the muzzle offset.
- It moves every active bullet and retires bullets at the playfield bounds or on a collision hit.
- It feeds the bullet sprite renderer and the collision logic.

Parameters:
- NUM_REQ, 4: tank requesters. Index 0 is the player.
- NUM_SLOTS, 4: bullet slots in the pool.
- BULLET_STEP, 2: pixels moved per frame.
- X_MIN, 80: playfield left edge, inclusive.
- X_MAX, 559: playfield right edge, inclusive.
- Y_MIN, 0: playfield top edge, inclusive.
- Y_MAX, 479: playfield bottom edge, inclusive.
- COOLDOWN, 16: frames after a grant before the same requester may be granted again.
- MAX_PER_REQ, 1: maximum simultaneously active bullets per requester.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  synchronous, active-high reset.
- fire_req  in  NUM_REQ  level fire request per tank.
- req_x  in  NUM_REQ*10  tank top-left X, packed, requester i at [10i+9:10i].
- req_y  in  NUM_REQ*10  tank top-left Y, packed the same way.
- req_dir  in  NUM_REQ*4  tank facing, one-hot: 0001 up, 0010 down, 0100 left, 1000 right.
- hit  in  NUM_SLOTS  collision kill per slot, sampled each frame.
- fire_ack  out  NUM_REQ  one-frame pulse for the granted requester.
- slot_active  out  NUM_SLOTS  slot occupied.
- slot_x  out  NUM_SLOTS*10  bullet top-left X, 8x8 sprite.
- slot_y  out  NUM_SLOTS*10  bullet top-left Y.
- slot_dir  out  NUM_SLOTS*4  bullet direction, one-hot.
- slot_owner  out  NUM_SLOTS*clog2(NUM_REQ)  owning requester.

Behaviour:
- **Reset:**
  - Reset is synchronous, active-high; the clock is frame_clk.
  - On reset: slot_active=0, slot_x=0, slot_y=0, slot_dir=0001, slot_owner=0, fire_ack=0, rr_ptr=0, all cooldowns=0, all owned counts=0.
  - Reset asserted mid-flight clears everything on that edge.
- **Slot update, every edge, per active slot i, in priority order:**
  - If hit[i]=1, the slot is freed.
  - Otherwise, if the next position leaves the playfield, the slot is freed. Up: y < Y_MIN+STEP. Down: y+8+STEP > Y_MAX+1. Left: x < X_MIN+STEP. Right: x+8+STEP > X_MAX+1.
  - Otherwise, x/y move by STEP in slot_dir.
  - hit on an inactive slot is ignored.
  - Freeing a slot decrements its owner's count on the same edge.
- **Eligibility of requester r:**
  - fire_req[r]=1, cooldown[r]=0, owned[r] < MAX_PER_REQ, and req_dir[r] is exactly one-hot.
  - The spawn position must lie within the playfield:
    - up (x+12, y-8), needs y ≥ Y_MIN+8;
    - down (x+12, y+32), needs y+40 ≤ Y_MAX+1;
    - left (x-8, y+12), needs x ≥ X_MIN+8;
    - right (x+32, y+12), needs x+40 ≤ X_MAX+1.
  - All arithmetic is done at 11 bits so no underflow wraps.
- **Arbitration, one grant per edge maximum:**
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; the first eligible one wins.
  - A grant happens only if some slot was inactive at the start of the cycle. A slot freed on this edge is not reusable until the next edge.
  - The winner gets the lowest-index free slot: active=1, spawn position, slot_dir=req_dir, slot_owner=r. The slot does not move on its spawn edge.
  - On grant: fire_ack[r]=1 for exactly one frame, cooldown[r]=COOLDOWN, owned[r]+1, rr_ptr=(r+1) mod NUM_REQ.
  - With no grant, fire_ack=0 and rr_ptr is unchanged.
- **Cooldowns:** each nonzero cooldown decrements by 1 per frame and saturates at 0. A requester held high fires again exactly COOLDOWN+1 frames after its previous grant if otherwise eligible.
- **Pool full:** requests stall with no ack and no state change except cooldown decrement. A held request is served once a slot frees.
- **Ordering:** ack is registered together with the slot state, so both become visible after the same edge.

Test Plan:
- **Single shot:** Reset; req0 held, x=320, y=240, dir=0001.
  - Edge 1: ack0=1, slot0 (332,232) up.
  - Edge 2: y=230, ack0=0.
  - Slot0 frees when y<2, i.e. the edge after y reaches 0.
- **Round-robin:** all four requesters held, legal positions, NUM_SLOTS=4.
  - Grants on consecutive edges go to 0,1,2,3 in slots 0,1,2,3.
  - Next request stalls with pool full.
- **Limits:** req1 held, MAX_PER_REQ=1.
  - No second ack while its bullet is live.
  - After a hit, a re-grant occurs only once cooldown has expired: not earlier than 17 frames after the first grant.
- **Hit vs exit:** slot moving right at x=550, hit asserted the same edge.
  - Slot frees once; owned count decrements by exactly 1.
  - A new request that edge does not take that slot until the next edge.
- **Spawn bounds:** req2 dir=0100 with x=85 → no ack, rr_ptr unchanged. Non-one-hot dir=0011 → ignored.
- **Reset mid-flight:** 3 slots active, Reset for 1 edge.
  - All outputs return to reset values.
  - Cooldowns clear, so a held req0 is granted on the first edge after Reset deasserts.
